// File: rtl/sqrt_sched_pkg.sv
// Shared types and widths for the square-root request scheduler.
package sqrt_sched_pkg;

  localparam int VALOR_W = 16;
  localparam int ROOT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sqrt_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// searching circularly. Purely combinational; the caller registers the result.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_k;

  // Circular priority search starting at the pointer.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int off = 0; off < N; off++) begin
      w_k = IDX_W'((int'(i_ptr) + off) % N);
      if (!o_valid && i_req[w_k]) begin
        o_valid    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/sqrt_req_scheduler.sv
// Shares one square-root core among N_REQ requesters. One request is in flight
// at a time: IDLE (arbitrate) -> LOAD (core restart) -> WAIT (result or
// timeout) -> DONE (report) -> IDLE.
//
// Handshake: a requester raises req_i[k] with its radicand on valor_i and holds
// both until it sees gnt_o[k] (one-cycle pulse, radicand captured at that
// point). The result is signalled later by a one-cycle done_o[k] pulse with
// root_o/lat_o/err_o valid in that same cycle; no back-pressure on the result.
module sqrt_req_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*VALOR_W-1:0]   valor_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           done_o,
  output logic                       err_o,
  output logic [ROOT_W-1:0]          root_o,
  output logic [CNT_W-1:0]           lat_o,
  output logic                       busy_o,
  output logic [VALOR_W-1:0]         core_valor_o,
  output logic                       core_rst_n_o,
  input  logic                       core_ready_i,
  input  logic [ROOT_W-1:0]          core_root_i,
  output sched_state_t               dbg_state_o
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_t       r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;
  logic               r_err;
  logic [ROOT_W-1:0]  r_root;
  logic [CNT_W-1:0]   r_lat;
  logic [CNT_W-1:0]   r_cnt;
  logic [VALOR_W-1:0] r_core_valor;
  logic               r_core_rst_n;

  logic [N_REQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic [VALOR_W-1:0] w_valor_sel;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ready_ok;
  logic               w_timeout;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [N_REQ-1:0]   w_owner_oh;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_valor_sel = valor_i[w_arb_idx*VALOR_W +: VALOR_W];
  assign w_cnt_nxt   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  // r_cnt is zero only in the first WAIT cycle, while the core is still
  // leaving restart, so its ready level is not trusted there.
  assign w_ready_ok  = core_ready_i && (r_cnt != '0);
  assign w_timeout   = (w_cnt_nxt == CNT_W'(TIMEOUT));
  assign w_ptr_nxt   = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_err        <= 1'b0;
      r_root       <= '0;
      r_lat        <= '0;
      r_cnt        <= '0;
      r_core_valor <= 16'hFFFF;
      r_core_rst_n <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_core_rst_n <= 1'b1;
          if (w_arb_valid) begin
            r_core_valor <= w_valor_sel;
            r_owner      <= w_arb_idx;
            r_gnt        <= w_arb_gnt;
            r_core_rst_n <= 1'b0;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          r_core_rst_n <= 1'b1;
          r_cnt        <= '0;
          r_state      <= WAIT;
        end
        WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (w_ready_ok) begin
            r_root  <= core_root_i;
            r_lat   <= w_cnt_nxt;
            r_done  <= w_owner_oh;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_root  <= '0;
            r_lat   <= w_cnt_nxt;
            r_done  <= w_owner_oh;
            r_err   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ptr   <= w_ptr_nxt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_o        = r_gnt;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign root_o       = r_root;
  assign lat_o        = r_lat;
  assign busy_o       = (r_state != IDLE);
  assign core_valor_o = r_core_valor;
  assign core_rst_n_o = r_core_rst_n;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// Bench for sqrt_req_scheduler: behavioural square-root core, requester
// driver, and a scoreboard of expected grants and results.
module tb_sqrt_req_scheduler;
  import sqrt_sched_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_i;
  logic [N_REQ*16-1:0]  valor_i;
  logic [N_REQ-1:0]     gnt_o;
  logic [N_REQ-1:0]     done_o;
  logic                 err_o;
  logic [7:0]           root_o;
  logic [CNT_W-1:0]     lat_o;
  logic                 busy_o;
  logic [15:0]          core_valor_o;
  logic                 core_rst_n_o;
  logic                 core_ready_i = 1'b0;
  logic [7:0]           core_root_i  = 8'd0;
  sched_state_t         dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  int core_delay = 5;
  int core_cnt = 0;

  // {done one-hot, err, root, lat} and {gnt one-hot, captured radicand}
  logic [23:0] exp_q[$];
  logic [19:0] gnt_q[$];
  logic [23:0] e_done;
  logic [19:0] e_gnt;

  sqrt_req_scheduler #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .valor_i      (valor_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .root_o       (root_o),
    .lat_o        (lat_o),
    .busy_o       (busy_o),
    .core_valor_o (core_valor_o),
    .core_rst_n_o (core_rst_n_o),
    .core_ready_i (core_ready_i),
    .core_root_i  (core_root_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= 32'(v)) r++;
    return 8'(r);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Core model: ready is visible in the core_delay-th cycle after restart is
  // released; core_delay = 0 means it never answers.
  always @(posedge clk) begin
    if (!core_rst_n_o) begin
      core_ready_i <= 1'b0;
      core_cnt     <= 0;
      core_root_i  <= isqrt(core_valor_o);
    end else if (!core_ready_i && core_delay != 0) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 >= core_delay - 1) core_ready_i <= 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt_o != '0) begin
        if (gnt_q.size() == 0) check_eq("gnt_unexp", 32'(gnt_o), 32'd0);
        else begin
          e_gnt = gnt_q.pop_front();
          check_eq("gnt", 32'({gnt_o, core_valor_o}), 32'(e_gnt));
        end
      end
      if (done_o != '0) begin
        if (exp_q.size() == 0) check_eq("done_unexp", 32'(done_o), 32'd0);
        else begin
          e_done = exp_q.pop_front();
          check_eq("done", 32'({done_o, err_o, root_o, lat_o}), 32'(e_done));
        end
      end else if (err_o) begin
        check_eq("err_stray", 32'(err_o), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_valor(input int k, input logic [15:0] v);
    valor_i[16*k +: 16] = v;
  endtask

  task automatic expect_req(input int k, input logic [15:0] v, input logic [7:0] root,
                            input int lat, input logic err);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    gnt_q.push_back({oh, v});
    exp_q.push_back({oh, err, root, 11'(lat)});
  endtask

  // Raise the requests in mask, drop each on its grant, return when idle.
  task automatic serve(input logic [3:0] mask, input int delay);
    bit ok;
    ok = 1'b0;
    core_delay = delay;
    req_i = req_i | mask;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      req_i = req_i & ~gnt_o;
      if (req_i == '0 && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("serve_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] v0, v2;
    int d;
    bit seen;
    rst = 1'b1;
    req_i = '0;
    valor_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", 32'(gnt_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_root", 32'(root_o), 32'd0);
    check_eq("rst_lat", 32'(lat_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_core_valor", 32'(core_valor_o), 32'hFFFF);
    check_eq("rst_core_rst_n", 32'(core_rst_n_o), 32'd0);
    check_eq("rst_state", 32'(dbg_state_o), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_core_rst_n", 32'(core_rst_n_o), 32'd1);

    // All four requesting: served in order 0..3 from pointer 0
    set_valor(0, 16'hFFFF);
    set_valor(1, 16'd256);
    set_valor(2, 16'd0);
    set_valor(3, 16'd2);
    d = $urandom_range(2, 40);
    expect_req(0, 16'hFFFF, 8'd255, d, 1'b0);
    expect_req(1, 16'd256,  8'd16,  d, 1'b0);
    expect_req(2, 16'd0,    8'd0,   d, 1'b0);
    expect_req(3, 16'd2,    8'd1,   d, 1'b0);
    serve(4'b1111, d);

    // Single requester, radicand 144, core answers in 9 cycles
    set_valor(0, 16'd144);
    expect_req(0, 16'd144, 8'd12, 9, 1'b0);
    serve(4'b0001, 9);

    // Pointer at 1: requester 2 before 0
    v0 = 16'($urandom_range(0, 65535));
    v2 = 16'($urandom_range(0, 65535));
    set_valor(0, v0);
    set_valor(2, v2);
    d = $urandom_range(2, 30);
    expect_req(2, v2, 8'(isqrt(v2)), d, 1'b0);
    expect_req(0, v0, 8'(isqrt(v0)), d, 1'b0);
    serve(4'b0101, d);

    // Move pointer to 3, then 0 is served before 2
    d = $urandom_range(2, 30);
    expect_req(2, v2, 8'(isqrt(v2)), d, 1'b0);
    serve(4'b0100, d);
    v0 = 16'($urandom_range(0, 65535));
    set_valor(0, v0);
    d = $urandom_range(2, 30);
    expect_req(0, v0, 8'(isqrt(v0)), d, 1'b0);
    expect_req(2, v2, 8'(isqrt(v2)), d, 1'b0);
    serve(4'b0101, d);

    // Core never answers: timeout after TIMEOUT cycles in WAIT
    set_valor(1, 16'd400);
    expect_req(1, 16'd400, 8'd0, TIMEOUT, 1'b1);
    serve(4'b0010, 0);

    // Ready in the very cycle the timeout would fire: ready wins
    set_valor(2, 16'd10000);
    expect_req(2, 16'd10000, 8'd100, TIMEOUT, 1'b0);
    serve(4'b0100, TIMEOUT);

    // One cycle too late: timeout
    set_valor(3, 16'd81);
    expect_req(3, 16'd81, 8'd0, TIMEOUT, 1'b1);
    serve(4'b1000, TIMEOUT + 1);

    // Next request served normally after a timeout; pointer moves to 3
    set_valor(2, 16'd49);
    expect_req(2, 16'd49, 8'd7, 9, 1'b0);
    serve(4'b0100, 9);

    // Reset during WAIT: no result for the aborted request, pointer back to 0
    set_valor(3, 16'd900);
    gnt_q.push_back({4'b1000, 16'd900});
    core_delay = 30;
    req_i = 4'b1000;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt_o[3]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("abort_gnt_timeout", 32'd0, 32'd1);
    req_i = '0;
    repeat (5) @(negedge clk);
    check_eq("abort_in_wait", 32'(dbg_state_o), 32'(WAIT));
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_state", 32'(dbg_state_o), 32'(IDLE));
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    check_eq("abort_done", 32'(done_o), 32'd0);
    check_eq("abort_root", 32'(root_o), 32'd0);
    check_eq("abort_core_rst_n", 32'(core_rst_n_o), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    set_valor(0, 16'd25);
    set_valor(3, 16'd900);
    expect_req(0, 16'd25,  8'd5,  6, 1'b0);
    expect_req(3, 16'd900, 8'd30, 6, 1'b0);
    serve(4'b1001, 6);

    repeat (3) @(negedge clk);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("gnt_q_empty", 32'(gnt_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
